// File: rtl/intersection_controller_pkg.sv
// Shared definitions for the intersection controller.
//   phase_e        : traffic phase encoding (GREEN / YELLOW / ALL_RED)
//   DEF_T_*        : default phase durations in clk cycles
//   idx_width()    : width of an approach index for a given approach count
package intersection_controller_pkg;

    typedef enum logic [1:0] {
        GREEN   = 2'b00,
        YELLOW  = 2'b01,
        ALL_RED = 2'b10
    } phase_e;

    localparam int DEF_N_APPROACH  = 4;
    localparam int DEF_TIMER_W     = 8;
    localparam int DEF_T_GREEN     = 20;
    localparam int DEF_T_MIN_GREEN = 5;
    localparam int DEF_T_YELLOW    = 4;
    localparam int DEF_T_ALL_RED   = 2;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/intersection_controller_rr_next_select.sv
// Round-robin search for the next approach to receive right-of-way.
//   demand_i : vehicle presence per approach
//   cur_i    : approach currently holding right-of-way
//   next_o   : first approach after cur_i (wrapping) with demand; cur_i+1 if none
module rr_next_select #(
    parameter int N_APPROACH = 4,
    parameter int IDX_W      = 2
) (
    input  logic [N_APPROACH-1:0] demand_i,
    input  logic [IDX_W-1:0]      cur_i,
    output logic [IDX_W-1:0]      next_o
);

    logic             found;
    logic [IDX_W-1:0] idx;

    // Offsets run 1..N so the current approach is considered last.
    always_comb begin
        next_o = IDX_W'((int'(cur_i) + 1) % N_APPROACH);
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= N_APPROACH; k++) begin
            idx = IDX_W'((int'(cur_i) + k) % N_APPROACH);
            if (!found && demand_i[idx]) begin
                next_o = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intersection_controller.sv
// Round-robin traffic intersection controller with pedestrian requests.
//   clk, reset        : clock, synchronous active-high reset
//   demand_i          : vehicle presence per approach (level)
//   ped_req_i         : pedestrian request per approach (bit i stops approach i)
//   green_o/yellow_o/red_o : lamp drives per approach
//   cur_approach_o    : approach holding right-of-way
//   ped_pending_o     : latched, unserved pedestrian requests
//   ped_served_o      : one-cycle pulse on YELLOW entry of a pending approach
//
// State table:
//   GREEN   | cur approach has right-of-way; may rest here with timer held
//   YELLOW  | cur approach clearing, fixed T_YELLOW cycles
//   ALL_RED | all approaches stopped, fixed T_ALL_RED cycles, then pick next
module intersection_controller
    import intersection_controller_pkg::*;
#(
    parameter int N_APPROACH  = DEF_N_APPROACH,
    parameter int TIMER_W     = DEF_TIMER_W,
    parameter int T_GREEN     = DEF_T_GREEN,
    parameter int T_MIN_GREEN = DEF_T_MIN_GREEN,
    parameter int T_YELLOW    = DEF_T_YELLOW,
    parameter int T_ALL_RED   = DEF_T_ALL_RED,
    localparam int IW         = idx_width(N_APPROACH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_APPROACH-1:0] demand_i,
    input  logic [N_APPROACH-1:0] ped_req_i,
    output logic [N_APPROACH-1:0] green_o,
    output logic [N_APPROACH-1:0] yellow_o,
    output logic [N_APPROACH-1:0] red_o,
    output logic [IW-1:0]         cur_approach_o,
    output logic [N_APPROACH-1:0] ped_pending_o,
    output logic [N_APPROACH-1:0] ped_served_o
);

    localparam int T_MAX = (2 ** TIMER_W) - 1;

    if (N_APPROACH < 2 || N_APPROACH > 8) begin : g_bad_n
        $error("N_APPROACH must be in 2..8");
    end
    if (T_GREEN == 0 || T_MIN_GREEN == 0 || T_YELLOW == 0 || T_ALL_RED == 0) begin : g_zero_t
        $error("phase durations must be non-zero");
    end
    if (T_MIN_GREEN > T_GREEN) begin : g_min_gt
        $error("T_MIN_GREEN must not exceed T_GREEN");
    end
    if (T_GREEN > T_MAX || T_MIN_GREEN > T_MAX || T_YELLOW > T_MAX || T_ALL_RED > T_MAX) begin : g_t_wide
        $error("phase duration does not fit in TIMER_W bits");
    end

    localparam logic [TIMER_W-1:0] TG_LAST  = TIMER_W'(T_GREEN - 1);
    localparam logic [TIMER_W-1:0] TMG_LAST = TIMER_W'(T_MIN_GREEN - 1);
    localparam logic [TIMER_W-1:0] TY_LAST  = TIMER_W'(T_YELLOW - 1);
    localparam logic [TIMER_W-1:0] TA_LAST  = TIMER_W'(T_ALL_RED - 1);

    phase_e                  state_q, state_d;
    logic [TIMER_W-1:0]      timer_q, timer_d;
    logic [IW-1:0]           cur_q, cur_d;
    logic [N_APPROACH-1:0]   pend_q, pend_d;
    logic [N_APPROACH-1:0]   served_q, served_d;
    logic [IW-1:0]           rr_next;
    logic [N_APPROACH-1:0]   cur_onehot;
    logic                    other_demand;
    logic                    ped_cur;
    logic                    go_yellow;

    rr_next_select #(
        .N_APPROACH (N_APPROACH),
        .IDX_W      (IW)
    ) u_rr_next_select (
        .demand_i (demand_i),
        .cur_i    (cur_q),
        .next_o   (rr_next)
    );

    assign cur_onehot   = N_APPROACH'(1) << cur_q;
    assign other_demand = |(demand_i & ~cur_onehot);
    assign ped_cur      = pend_q[cur_q];
    // Early exit for a pedestrian after minimum green; normal exit at full
    // green if anyone else is waiting. Timer is held at TG_LAST while resting.
    assign go_yellow    = (ped_cur && timer_q >= TMG_LAST) ||
                          (timer_q >= TG_LAST && (other_demand || ped_cur));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= GREEN;
            timer_q  <= '0;
            cur_q    <= '0;
            pend_q   <= '0;
            served_q <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            cur_q    <= cur_d;
            pend_q   <= pend_d;
            served_q <= served_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + 1'b1;
        cur_d    = cur_q;
        served_d = '0;
        pend_d   = pend_q | ped_req_i;
        unique case (state_q)
            GREEN: begin
                if (go_yellow) begin
                    state_d  = YELLOW;
                    timer_d  = '0;
                    served_d = pend_q & cur_onehot;
                    // A request arriving in the clear cycle re-latches.
                    pend_d   = (pend_q & ~cur_onehot) | ped_req_i;
                end else if (timer_q >= TG_LAST) begin
                    timer_d = timer_q;
                end
            end
            YELLOW: begin
                if (timer_q == TY_LAST) begin
                    state_d = ALL_RED;
                    timer_d = '0;
                end
            end
            ALL_RED: begin
                if (timer_q == TA_LAST) begin
                    state_d = GREEN;
                    timer_d = '0;
                    cur_d   = rr_next;
                end
            end
            default: begin
                state_d = GREEN;
                timer_d = '0;
            end
        endcase
    end

    assign green_o        = (state_q == GREEN)  ? cur_onehot : '0;
    assign yellow_o       = (state_q == YELLOW) ? cur_onehot : '0;
    assign red_o          = ~(green_o | yellow_o);
    assign cur_approach_o = cur_q;
    assign ped_pending_o  = pend_q;
    assign ped_served_o   = served_q;

endmodule

// File: tb/tb_intersection_controller.sv
module tb_intersection_controller;

    localparam int N    = 4;
    localparam int TG   = 20;
    localparam int TMG  = 5;
    localparam int TY   = 4;
    localparam int TAR  = 2;

    logic         clk;
    logic         reset;
    logic [N-1:0] demand;
    logic [N-1:0] ped_req;
    logic [N-1:0] green, yellow, red, pend, served;
    logic [1:0]   cur;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Behavioural model: phase (0 green, 1 yellow, 2 all-red), time spent in
    // the phase, approach owning right-of-way, pedestrian latches.
    int       m_phase;
    int       m_age;
    int       m_cur;
    logic [N-1:0] m_pend;
    logic [N-1:0] m_served;
    bit       m_valid = 0;

    intersection_controller dut (
        .clk            (clk),
        .reset          (reset),
        .demand_i       (demand),
        .ped_req_i      (ped_req),
        .green_o        (green),
        .yellow_o       (yellow),
        .red_o          (red),
        .cur_approach_o (cur),
        .ped_pending_o  (pend),
        .ped_served_o   (served)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick_next(input logic [N-1:0] d, input int c);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (c + k) % N;
            if (((d >> j) & 4'd1) != 4'd0) return j;
        end
        return (c + 1) % N;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_phase  = 0;
            m_age    = 0;
            m_cur    = 0;
            m_pend   = '0;
            m_served = '0;
            m_valid  = 1;
            cyc      = 0;
        end else begin
            logic [N-1:0] mask;
            bit others, pc;
            cyc++;
            mask     = 4'd1 << m_cur;
            others   = (demand & ~mask) != '0;
            pc       = (m_pend & mask) != '0;
            m_served = '0;
            if (m_phase == 0) begin
                if ((pc && m_age + 1 >= TMG) || (m_age + 1 >= TG && (others || pc))) begin
                    m_served = m_pend & mask;
                    m_pend   = (m_pend & ~mask) | ped_req;
                    m_phase  = 1;
                    m_age    = 0;
                end else begin
                    m_pend = m_pend | ped_req;
                    m_age++;
                end
            end else begin
                m_pend = m_pend | ped_req;
                if (m_phase == 1 && m_age + 1 == TY) begin
                    m_phase = 2;
                    m_age   = 0;
                end else if (m_phase == 2 && m_age + 1 == TAR) begin
                    m_phase = 0;
                    m_age   = 0;
                    m_cur   = pick_next(demand, m_cur);
                end else begin
                    m_age++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            logic [N-1:0] eg, ey;
            eg = (m_phase == 0) ? (4'd1 << m_cur) : 4'd0;
            ey = (m_phase == 1) ? (4'd1 << m_cur) : 4'd0;
            n_vec++;
            if (green !== eg || yellow !== ey || red !== ~(eg | ey) ||
                int'(cur) != m_cur || pend !== m_pend || served !== m_served) begin
                n_err++;
                $display("FAIL model cycle %0d: got g=%b y=%b r=%b cur=%0d pend=%b srv=%b, want g=%b y=%b r=%b cur=%0d pend=%b srv=%b",
                         cyc, green, yellow, red, cur, pend, served,
                         eg, ey, ~(eg | ey), m_cur, m_pend, m_served);
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %b want %b", name, cyc, act, exp);
        end
    endtask

    task automatic goto(input int k);
        int guard;
        guard = 0;
        while (cyc < k && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        n_vec++;
        if (cyc != k) begin
            n_err++;
            $display("FAIL goto: at cycle %0d want %0d", cyc, k);
        end
    endtask

    task automatic do_reset(input logic [N-1:0] d);
        @(negedge clk);
        reset   = 1'b1;
        demand  = d;
        ped_req = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        demand  = '0;
        ped_req = '0;

        // All approaches demanding: full round-robin rotation with wrap.
        do_reset(4'b1111);
        check("rst_green",  8'(green),  8'b0001);
        check("rst_yellow", 8'(yellow), 8'b0000);
        check("rst_red",    8'(red),    8'b1110);
        check("rst_pend",   8'(pend),   8'b0000);
        check("rst_served", 8'(served), 8'b0000);
        goto(19); check("a_green19",  8'(green),  8'b0001);
        goto(20); check("a_yellow20", 8'(yellow), 8'b0001);
        goto(23); check("a_yellow23", 8'(yellow), 8'b0001);
        goto(24); check("a_allred24", 8'(red),    8'b1111);
        goto(25); check("a_allred25", 8'(red),    8'b1111);
        goto(26); check("a_green1",   8'(green),  8'b0010);
                  check("a_cur1",     8'(cur),    8'd1);
        goto(78); check("a_green3",   8'(green),  8'b1000);
        goto(104); check("a_wrap_cur", 8'(cur),   8'd0);
                   check("a_wrap_g",   8'(green), 8'b0001);

        // Pedestrian early exit, then set-wins in the clear cycle.
        do_reset(4'b0000);
        goto(2); ped_req = 4'b0001;
        goto(3); ped_req = 4'b0000;
        check("b_pend3", 8'(pend), 8'b0001);
        goto(4); check("b_green4", 8'(green), 8'b0001);
        goto(5);
        check("b_yellow5", 8'(yellow), 8'b0001);
        check("b_served5", 8'(served), 8'b0001);
        check("b_pend5",   8'(pend),   8'b0000);
        goto(6); check("b_served6", 8'(served), 8'b0000);
        goto(11); check("b_green1", 8'(green), 8'b0010);
        ped_req = 4'b0010;
        goto(12); ped_req = 4'b0000;
        check("b_pend12", 8'(pend), 8'b0010);
        goto(15); ped_req = 4'b0010;
        goto(16); ped_req = 4'b0000;
        check("b_yellow16", 8'(yellow), 8'b0010);
        check("b_served16", 8'(served), 8'b0010);
        check("b_pend16",   8'(pend),   8'b0010);
        goto(50); check("b_rest2", 8'(green), 8'b0100);

        // Single distant demand: skip idle approaches.
        do_reset(4'b0100);
        goto(25); check("c_allred25", 8'(red), 8'b1111);
        goto(26);
        check("c_green2", 8'(green), 8'b0100);
        check("c_cur2",   8'(cur),   8'd2);
        goto(80); check("c_rest2", 8'(green), 8'b0100);

        // Rest in green on own demand, leave when another approach arrives.
        do_reset(4'b0001);
        goto(39); check("d_rest39", 8'(green), 8'b0001);
        goto(40); demand = 4'b1001;
        goto(41); check("d_yellow41", 8'(yellow), 8'b0001);
        goto(47);
        check("d_green3", 8'(green), 8'b1000);
        check("d_cur3",   8'(cur),   8'd3);

        // Reset in the middle of approach 1 yellow, with a latched request.
        do_reset(4'b1111);
        goto(30); ped_req = 4'b0100;
        goto(31); ped_req = 4'b0000;
        goto(47);
        check("e_yellow1", 8'(yellow), 8'b0010);
        check("e_pend",    8'(pend),   8'b0100);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("e_green0", 8'(green),  8'b0001);
        check("e_cur0",   8'(cur),    8'd0);
        check("e_pend0",  8'(pend),   8'b0000);
        check("e_yel0",   8'(yellow), 8'b0000);
        goto(19); check("e_green19",  8'(green),  8'b0001);
        goto(20); check("e_yellow20", 8'(yellow), 8'b0001);
        goto(30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/intersection_controller.md
INTERSECTION_CONTROLLER -- requirements
Module: intersection_controller

Interface
REQ-001 Parameter N_APPROACH, default 4, number of approaches served round-robin; range 2..8.
REQ-002 Parameter TIMER_W, default 8, phase timer width in bits.
REQ-003 Parameters T_GREEN=20, T_MIN_GREEN=5, T_YELLOW=4, T_ALL_RED=2 SHALL set phase durations in clk cycles.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 demand  input  N_APPROACH  vehicle presence per approach; level-sensitive.
REQ-007 ped_req  input  N_APPROACH  pedestrian crossing request per approach; bit i asks approach i to stop.
REQ-008 green, yellow, red  output  N_APPROACH each  lamp drives per approach.
REQ-009 cur_approach  output  max(1,clog2(N_APPROACH))  index of the approach holding right-of-way.
REQ-010 ped_pending  output  N_APPROACH  latched, unserved pedestrian requests.
REQ-011 ped_served  output  N_APPROACH  one-cycle pulse when a pedestrian request is served.

Function
REQ-012 Phase FSM states SHALL be GREEN, YELLOW, ALL_RED; timer clears to 0 on every state entry and otherwise increments by 1 per cycle.
REQ-013 GREEN -> YELLOW SHALL occur the cycle after timer==T_GREEN-1 if any demand[j] (j!=cur) or ped_pending[cur] is 1.
REQ-014 GREEN -> YELLOW SHALL occur early the cycle after a cycle with ped_pending[cur]==1 and timer>=T_MIN_GREEN-1.
REQ-015 When GREEN reaches timer==T_GREEN-1 with neither condition true, the FSM SHALL rest in GREEN with the timer held at T_GREEN-1 and SHALL leave it the cycle after a condition becomes true.
REQ-016 YELLOW SHALL last exactly T_YELLOW cycles and ALL_RED exactly T_ALL_RED cycles.
REQ-017 On ALL_RED exit, cur SHALL become the first j in cur+1, cur+2, ... (mod N_APPROACH) with demand[j]==1, sampled that cycle; if none, (cur+1) mod N_APPROACH.
REQ-018 green[i] SHALL be 1 only for i==cur in GREEN, yellow[i] only for i==cur in YELLOW, red[i]=~(green[i]|yellow[i]); exactly one lamp per approach is lit at all times.
REQ-019 ped_pending[i] SHALL set the cycle after ped_req[i]==1 and clear on YELLOW entry for approach i, when ped_served[i] pulses for exactly that cycle.
REQ-020 If ped_req[i] is 1 in the clear cycle, set SHALL win: ped_pending[i] stays 1 and ped_served[i] still pulses.
REQ-021 All outputs SHALL be decoded from registers only; no combinational path from any input to any output.

Reset
REQ-022 With reset high at a clock edge: state=GREEN, cur=0, timer=0, ped_pending=0, ped_served=0, green=1 on bit 0 only, yellow=0, red=1 on all bits except 0.
REQ-023 Reset SHALL take priority over every transition, including mid-YELLOW or mid-ALL_RED, and SHALL discard latched requests.

Structure
REQ-024 Shared package SHALL hold the phase-state enum (GREEN=2'b00, YELLOW=2'b01, ALL_RED=2'b10) and default timing constants.
REQ-025 The round-robin next-approach search SHALL be a separate combinational sub-module rr_next_select (inputs demand, cur; output next index).
REQ-026 Elaboration SHALL fail if N_APPROACH<2, any time is 0, T_MIN_GREEN>T_GREEN, or any time exceeds 2**TIMER_W-1.

Verification (defaults; cycle 0 = first edge after reset release)
REQ-027 demand=4'b1111, no ped -> green[0] cycles 0-19, yellow[0] 20-23, all red 24-25, green[1] from 26; after approach 3, cur wraps to 0.
REQ-028 ped_req[0] pulsed at cycle 2 -> ped_pending[0]=1 from cycle 3, yellow[0] and ped_served[0] pulse at cycle 5.
REQ-029 demand=4'b0100 -> after approach 0 green/yellow/all-red, cur=2 with green[2]=1 at cycle 26.
REQ-030 demand=4'b0001 -> approach 0 rests green, timer held 19; demand[3] raised at cycle 40 -> yellow[0] at cycle 41, green[3] at cycle 47.
REQ-031 reset asserted during YELLOW of approach 1 -> next cycle green[0]=1, cur=0, ped_pending=0, timer=0.
